dcache_wb2way: RTL and testbench

- Write-back, 2-way set-associative data cache between the pipelined datapath's memory stage and the memory bus controller.
- Serves dmemREN/dmemWEN requests and returns dhit/dmemload.
- Fills and evicts 2-word blocks over the bus.
- On datapath halt, writes back every dirty block, then asserts flushed.

---
 rtl/cache_types_pkg.sv | 42 ++++
 rtl/dcache_set_store.sv | 51 +++++
 rtl/dcache_wb2way.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_dcache_wb2way.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared types for the 2-way write-back data cache.
// FSM state list gains CNT when DCACHE_HIT_COUNTER_EN is defined.
package cache_types_pkg;

  localparam int DBLK_WORDS = 2;
  localparam int DIDX_W     = 3;
  localparam int DTAG_W     = 32 - 3 - DIDX_W;
  // frame tag is wide enough for any set count
  localparam int FTAG_W     = 29;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcachef_t;

  typedef struct packed {
    logic                         valid;
    logic                         dirty;
    logic [FTAG_W-1:0]            tag;
    word_t [DBLK_WORDS-1:0]       data;
  } dcache_frame_t;

  typedef enum logic [3:0] {
    IDLE,
    WB0,
    WB1,
    LD0,
    LD1,
    FLUSH,
    FL_W0,
    FL_W1,
`ifdef DCACHE_HIT_COUNTER_EN
    CNT,
`endif
    HALTED
  } dstate_t;

endpackage

// File: rtl/dcache_set_store.sv
// Frame and LRU storage for the 2-way data cache.
// Combinational read port, clocked write port, reset-clearable.
module dcache_set_store
  import cache_types_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [IDX_W-1:0]    rd_idx,
  output dcache_frame_t [1:0] rd_frame,
  output logic                rd_lru,
  input  logic [1:0]          frame_we,
  input  logic [IDX_W-1:0]    wr_idx,
  input  dcache_frame_t       wr_frame,
  input  logic                lru_we,
  input  logic                lru_val
);

  dcache_frame_t way0 [SETS];
  dcache_frame_t way1 [SETS];
  logic [SETS-1:0] lru;

  assign rd_frame[0] = way0[rd_idx];
  assign rd_frame[1] = way1[rd_idx];
  assign rd_lru      = lru[rd_idx];

  // frame writes; reset invalidates and cleans every line
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) begin
        way0[i] <= '0;
        way1[i] <= '0;
      end
    end else begin
      if (frame_we[0]) way0[wr_idx] <= wr_frame;
      if (frame_we[1]) way1[wr_idx] <= wr_frame;
    end
  end

  // per-set victim pointer, 0 selects way0
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lru <= '0;
    end else if (lru_we) begin
      lru[wr_idx] <= lru_val;
    end
  end

endmodule

// File: rtl/dcache_wb2way.sv
// Write-back 2-way set-associative data cache with halt flush.
// Optional hit counter write-out: DCACHE_HIT_COUNTER_EN.
module dcache_wb2way
  import cache_types_pkg::*;
#(
  parameter int          SETS     = 8,
  parameter logic [31:0] CNT_ADDR = 32'h00003100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 3 - IDX_W;

`ifdef DCACHE_HIT_COUNTER_EN
  localparam dstate_t FL_DONE = CNT;
`else
  localparam dstate_t FL_DONE = HALTED;
`endif

  dstate_t             state;
  logic [FTAG_W-1:0]   m_tag;
  logic [IDX_W-1:0]    m_idx;
  logic                vway;
  logic                f_way;
  logic [IDX_W-1:0]    f_idx;

  logic [FTAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic                req_blk;
  logic                req;

  logic [IDX_W-1:0]    rd_idx;
  dcache_frame_t [1:0] rf;
  logic                rd_lru;
  logic [1:0]          frame_we;
  logic [IDX_W-1:0]    wr_idx;
  dcache_frame_t       wr_frame;
  logic                lru_we;
  logic                lru_val;

  logic                hit0;
  logic                hit1;
  logic                hit;
  logic                hway;
  logic                sec;
  logic                last_slot;
  dcache_frame_t       hf;
  dcache_frame_t       vf;
  dcache_frame_t       ff;
  dcache_frame_t       lf;

  logic                unused_ok;

  assign req_tag = FTAG_W'(dmemaddr[31:3+IDX_W]);
  assign req_idx = dmemaddr[2+IDX_W:3];
  assign req_blk = dmemaddr[2];
  assign req     = dmemREN | dmemWEN;

  dcache_set_store #(
    .SETS  (SETS),
    .IDX_W (IDX_W)
  ) u_store (
    .CLK      (CLK),
    .nRST     (nRST),
    .rd_idx   (rd_idx),
    .rd_frame (rf),
    .rd_lru   (rd_lru),
    .frame_we (frame_we),
    .wr_idx   (wr_idx),
    .wr_frame (wr_frame),
    .lru_we   (lru_we),
    .lru_val  (lru_val)
  );

  // read index follows the request, the miss, or the flush walk
  always_comb begin
    rd_idx = req_idx;
    if (state == FLUSH || state == FL_W0 || state == FL_W1)
      rd_idx = f_idx;
    else if (state != IDLE)
      rd_idx = m_idx;
  end

  assign hit0 = rf[0].valid && (rf[0].tag == req_tag);
  assign hit1 = rf[1].valid && (rf[1].tag == req_tag);
  assign hit  = hit0 | hit1;
  assign hway = ~hit0;
  assign hf   = rf[hway];
  assign vf   = rf[vway];
  assign ff   = rf[f_way];
  assign lf   = rf[rd_lru];

  assign sec = (state == WB1) || (state == LD1) ||
               (state == FL_W1);
  assign last_slot = &{f_way, f_idx};

  assign dhit     = (state == IDLE) && req && hit;
  assign dmemload = dhit ? hf.data[req_blk] : '0;
  assign flushed  = (state == HALTED);

`ifdef DCACHE_HIT_COUNTER_EN
  logic signed [31:0] cnt;
  logic               fill_hit;

  // hits minus misses; the hit that ends a fill is not counted
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt      <= '0;
      fill_hit <= 1'b0;
    end else begin
      if (state == LD1 && !dwait)
        fill_hit <= 1'b1;
      else if (state == IDLE)
        fill_hit <= 1'b0;
      if (state == IDLE && req) begin
        if (!hit)
          cnt <= cnt - 32'sd1;
        else if (!fill_hit)
          cnt <= cnt + 32'sd1;
      end
    end
  end

  assign unused_ok = ^dmemaddr[1:0];
`else
  assign unused_ok = ^{dmemaddr[1:0], CNT_ADDR};
`endif

  // bus requests decoded from the current state
  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = '0;
    dstore = '0;
    unique case (state)
      WB0, WB1: begin
        dWEN   = 1'b1;
        daddr  = {vf.tag[TAG_W-1:0], m_idx, sec, 2'b00};
        dstore = vf.data[sec];
      end
      LD0, LD1: begin
        dREN  = 1'b1;
        daddr = {m_tag[TAG_W-1:0], m_idx, sec, 2'b00};
      end
      FL_W0, FL_W1: begin
        dWEN   = 1'b1;
        daddr  = {ff.tag[TAG_W-1:0], f_idx, sec, 2'b00};
        dstore = ff.data[sec];
      end
`ifdef DCACHE_HIT_COUNTER_EN
      CNT: begin
        dWEN   = 1'b1;
        daddr  = CNT_ADDR;
        dstore = cnt;
      end
`endif
      default: ;
    endcase
  end

  // array updates: hit store/LRU, fill words, flush clean
  always_comb begin
    frame_we = '0;
    wr_idx   = req_idx;
    wr_frame = hf;
    lru_we   = 1'b0;
    lru_val  = 1'b0;
    unique case (state)
      IDLE: begin
        if (dhit) begin
          lru_we  = 1'b1;
          lru_val = ~hway;
          if (dmemWEN) begin
            frame_we[hway]         = 1'b1;
            wr_frame.dirty         = 1'b1;
            wr_frame.data[req_blk] = dmemstore;
          end
        end
      end
      LD0: begin
        wr_idx   = m_idx;
        wr_frame = vf;
        if (!dwait) begin
          frame_we[vway]   = 1'b1;
          wr_frame.data[0] = dload;
        end
      end
      LD1: begin
        wr_idx   = m_idx;
        wr_frame = vf;
        if (!dwait) begin
          frame_we[vway]   = 1'b1;
          wr_frame.data[1] = dload;
          wr_frame.valid   = 1'b1;
          wr_frame.dirty   = 1'b0;
          wr_frame.tag     = m_tag;
        end
      end
      FL_W1: begin
        wr_idx   = f_idx;
        wr_frame = ff;
        if (!dwait) begin
          frame_we[f_way] = 1'b1;
          wr_frame.dirty  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // cache controller FSM
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      m_tag <= '0;
      m_idx <= '0;
      vway  <= 1'b0;
      f_way <= 1'b0;
      f_idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (!hit) begin
              m_tag <= req_tag;
              m_idx <= req_idx;
              vway  <= rd_lru;
              state <= (lf.valid && lf.dirty) ? WB0 : LD0;
            end
          end else if (halt) begin
            f_way <= 1'b0;
            f_idx <= '0;
            state <= FLUSH;
          end
        end
        WB0: if (!dwait) state <= WB1;
        WB1: if (!dwait) state <= LD0;
        LD0: if (!dwait) state <= LD1;
        LD1: if (!dwait) state <= IDLE;
        FLUSH: begin
          if (ff.valid && ff.dirty)
            state <= FL_W0;
          else if (last_slot)
            state <= FL_DONE;
          else
            {f_way, f_idx} <= {f_way, f_idx} + 1'b1;
        end
        FL_W0: if (!dwait) state <= FL_W1;
        FL_W1: begin
          if (!dwait) begin
            if (last_slot) begin
              state <= FL_DONE;
            end else begin
              {f_way, f_idx} <= {f_way, f_idx} + 1'b1;
              state <= FLUSH;
            end
          end
        end
`ifdef DCACHE_HIT_COUNTER_EN
        CNT: if (!dwait) state <= HALTED;
`endif
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb2way.sv
// Directed bench for dcache_wb2way with a bus responder
// that models memory and logs every completed transfer.
module tb_dcache_wb2way;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0;
  logic [31:0] dmemstore = '0;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait = 1'b1;
  logic [31:0] dload = '0;

  dcache_wb2way dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .halt      (halt),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .flushed   (flushed),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dwait     (dwait),
    .dload     (dload)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int hits = 0;
  int misses = 0;
  int wait_cycles = 0;
  int wcnt = 0;
  logic        moved = 1'b0;
  logic [31:0] hold_addr = '0;

  logic [31:0] bmem [logic [31:0]];
  logic        lg_we [$];
  logic [31:0] lg_addr [$];
  logic [31:0] lg_data [$];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return dflt(a);
  endfunction

  // bus responder: wait_cycles busy cycles, then one done cycle
  always @(negedge CLK) begin
    if (nRST && (dREN || dWEN)) begin
      if (wcnt == 0) hold_addr = daddr;
      else if (daddr !== hold_addr) moved = 1'b1;
      if (wcnt < wait_cycles) begin
        dwait = 1'b1;
        wcnt++;
      end else begin
        dwait = 1'b0;
        wcnt = 0;
        lg_we.push_back(dWEN);
        lg_addr.push_back(daddr);
        if (dWEN) begin
          bmem[daddr] = dstore;
          lg_data.push_back(dstore);
        end else begin
          dload = rd_mem(daddr);
          lg_data.push_back(dload);
        end
      end
    end else begin
      dwait = 1'b1;
      wcnt = 0;
    end
  end

  task automatic do_req(input logic ren, input logic wen,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output int cyc,
                        output logic [31:0] ld);
    @(negedge CLK);
    dmemREN = ren;
    dmemWEN = wen;
    dmemaddr = a;
    dmemstore = d;
    cyc = 0;
    #1;
    while (!dhit && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      #1;
    end
    ld = dmemload;
    checks++;
    if (dhit !== 1'b1) begin
      $display("FAIL req_timeout addr=%h got dhit=%b want 1",
               a, dhit);
      errors++;
    end
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    if (cyc == 0) hits++;
    else misses++;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (dhit !== 1'b0 || flushed !== 1'b0) begin
      $display("FAIL reset_flags got dhit=%b flushed=%b want 0 0",
               dhit, flushed);
      errors++;
    end
    checks++;
    if (dREN !== 1'b0 || dWEN !== 1'b0) begin
      $display("FAIL reset_bus got dREN=%b dWEN=%b want 0 0",
               dREN, dWEN);
      errors++;
    end
    checks++;
    if (daddr !== 32'h0 || dstore !== 32'h0 ||
        dmemload !== 32'h0) begin
      $display("FAIL reset_data got %h %h %h want 0",
               daddr, dstore, dmemload);
      errors++;
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    #1;
    checks++;
    if (dhit !== 1'b0 || dREN !== 1'b0) begin
      $display("FAIL idle_no_req got dhit=%b dREN=%b want 0 0",
               dhit, dREN);
      errors++;
    end
  endtask

  task automatic test_cold_load;
    int n0, cyc;
    logic [31:0] ld;
    n0 = lg_addr.size();
    do_req(1'b1, 1'b0, 32'h40, 32'h0, cyc, ld);
    checks++;
    if (cyc != 3) begin
      $display("FAIL cold_latency got %0d want 3", cyc);
      errors++;
    end
    checks++;
    if (ld !== 32'hAAAA0000) begin
      $display("FAIL cold_data got %h want aaaa0000", ld);
      errors++;
    end
    checks++;
    if (lg_addr.size() != n0 + 2 ||
        lg_addr[n0] !== 32'h40 || lg_we[n0] !== 1'b0 ||
        lg_addr[n0+1] !== 32'h44 || lg_we[n0+1] !== 1'b0) begin
      $display("FAIL cold_bus got n=%0d a0=%h a1=%h want 2 40 44",
               lg_addr.size() - n0, lg_addr[n0], lg_addr[n0+1]);
      errors++;
    end
    n0 = lg_addr.size();
    do_req(1'b1, 1'b0, 32'h44, 32'h0, cyc, ld);
    checks++;
    if (cyc != 0 || ld !== 32'hAAAA0004) begin
      $display("FAIL word1_hit got cyc=%0d %h want 0 aaaa0004",
               cyc, ld);
      errors++;
    end
    checks++;
    if (lg_addr.size() != n0) begin
      $display("FAIL word1_nobus got %0d want 0",
               lg_addr.size() - n0);
      errors++;
    end
  endtask

  task automatic test_store_hit;
    int n0, cyc;
    logic [31:0] ld;
    n0 = lg_addr.size();
    do_req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, cyc, ld);
    checks++;
    if (cyc != 0) begin
      $display("FAIL store_hit_latency got %0d want 0", cyc);
      errors++;
    end
    do_req(1'b1, 1'b1, 32'h44, 32'h12345678, cyc, ld);
    checks++;
    if (cyc != 0) begin
      $display("FAIL both_req_latency got %0d want 0", cyc);
      errors++;
    end
    do_req(1'b1, 1'b0, 32'h40, 32'h0, cyc, ld);
    checks++;
    if (ld !== 32'hDEADBEEF) begin
      $display("FAIL store_readback got %h want deadbeef", ld);
      errors++;
    end
    do_req(1'b1, 1'b0, 32'h44, 32'h0, cyc, ld);
    checks++;
    if (ld !== 32'h12345678) begin
      $display("FAIL both_is_store got %h want 12345678", ld);
      errors++;
    end
    checks++;
    if (lg_addr.size() != n0) begin
      $display("FAIL store_nobus got %0d want 0",
               lg_addr.size() - n0);
      errors++;
    end
  endtask

  task automatic test_evict;
    int n0, cyc;
    logic [31:0] ld;
    logic        ew [4];
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    do_req(1'b1, 1'b0, 32'h0, 32'h0, cyc, ld);
    checks++;
    if (cyc != 3 || ld !== dflt(32'h0)) begin
      $display("FAIL fill_way1 got cyc=%0d %h want 3 %h",
               cyc, ld, dflt(32'h0));
      errors++;
    end
    do_req(1'b0, 1'b1, 32'h0, 32'h11111111, cyc, ld);
    n0 = lg_addr.size();
    do_req(1'b1, 1'b0, 32'h80, 32'h0, cyc, ld);
    checks++;
    if (cyc != 5 || ld !== dflt(32'h80)) begin
      $display("FAIL dirty_miss got cyc=%0d %h want 5 %h",
               cyc, ld, dflt(32'h80));
      errors++;
    end
    ew = '{1'b1, 1'b1, 1'b0, 1'b0};
    ea = '{32'h40, 32'h44, 32'h80, 32'h84};
    ed = '{32'hDEADBEEF, 32'h12345678,
           dflt(32'h80), dflt(32'h84)};
    checks++;
    if (lg_addr.size() != n0 + 4) begin
      $display("FAIL evict_count got %0d want 4",
               lg_addr.size() - n0);
      errors++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lg_we[n0+i] !== ew[i] || lg_addr[n0+i] !== ea[i] ||
          lg_data[n0+i] !== ed[i]) begin
        $display("FAIL evict_xfer%0d got %b %h %h want %b %h %h",
                 i, lg_we[n0+i], lg_addr[n0+i], lg_data[n0+i],
                 ew[i], ea[i], ed[i]);
        errors++;
      end
    end
    do_req(1'b1, 1'b0, 32'h0, 32'h0, cyc, ld);
    checks++;
    if (cyc != 0 || ld !== 32'h11111111) begin
      $display("FAIL mru_kept got cyc=%0d %h want 0 11111111",
               cyc, ld);
      errors++;
    end
  endtask

  task automatic test_wait_states;
    int n0, cyc;
    logic [31:0] ld;
    logic        ew [4];
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    wait_cycles = 5;
    moved = 1'b0;
    n0 = lg_addr.size();
    do_req(1'b1, 1'b0, 32'h100, 32'h0, cyc, ld);
    checks++;
    if (cyc != 13 || lg_addr.size() != n0 + 2) begin
      $display("FAIL slow_clean got cyc=%0d n=%0d want 13 2",
               cyc, lg_addr.size() - n0);
      errors++;
    end
    checks++;
    if (ld !== dflt(32'h100)) begin
      $display("FAIL slow_clean_data got %h want %h",
               ld, dflt(32'h100));
      errors++;
    end
    n0 = lg_addr.size();
    do_req(1'b1, 1'b0, 32'h140, 32'h0, cyc, ld);
    checks++;
    if (cyc != 25 || lg_addr.size() != n0 + 4) begin
      $display("FAIL slow_dirty got cyc=%0d n=%0d want 25 4",
               cyc, lg_addr.size() - n0);
      errors++;
    end
    ew = '{1'b1, 1'b1, 1'b0, 1'b0};
    ea = '{32'h0, 32'h4, 32'h140, 32'h144};
    ed = '{32'h11111111, dflt(32'h4),
           dflt(32'h140), dflt(32'h144)};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lg_we[n0+i] !== ew[i] || lg_addr[n0+i] !== ea[i] ||
          lg_data[n0+i] !== ed[i]) begin
        $display("FAIL slow_xfer%0d got %b %h %h want %b %h %h",
                 i, lg_we[n0+i], lg_addr[n0+i], lg_data[n0+i],
                 ew[i], ea[i], ed[i]);
        errors++;
      end
    end
    checks++;
    if (moved !== 1'b0) begin
      $display("FAIL daddr_stable got moved=%b want 0", moved);
      errors++;
    end
    wait_cycles = 0;
  endtask

  task automatic test_flush;
    int n0, cyc, nexp;
    logic [31:0] ld;
    logic [31:0] ea [7];
    logic [31:0] ed [7];
    logic        done;
    do_req(1'b0, 1'b1, 32'h140, 32'hC0DE0003, cyc, ld);
    do_req(1'b0, 1'b1, 32'h008, 32'hC0DE0001, cyc, ld);
    do_req(1'b0, 1'b1, 32'h018, 32'hC0DE0002, cyc, ld);
    checks++;
    if (cyc != 3) begin
      $display("FAIL store_miss_latency got %0d want 3", cyc);
      errors++;
    end
    ea = '{32'h008, 32'h00C, 32'h018, 32'h01C,
           32'h140, 32'h144, 32'h3100};
    ed = '{32'hC0DE0001, dflt(32'h00C),
           32'hC0DE0002, dflt(32'h01C),
           32'hC0DE0003, dflt(32'h144),
           32'(hits - misses)};
`ifdef DCACHE_HIT_COUNTER_EN
    nexp = 7;
`else
    nexp = 6;
`endif
    n0 = lg_addr.size();
    @(negedge CLK);
    halt = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge CLK);
      #1;
      done = flushed;
    end
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL flush_done got flushed=%b want 1", done);
      errors++;
    end
    checks++;
    if (lg_addr.size() != n0 + nexp) begin
      $display("FAIL flush_count got %0d want %0d",
               lg_addr.size() - n0, nexp);
      errors++;
    end
    for (int i = 0; i < nexp; i++) begin
      checks++;
      if (lg_we[n0+i] !== 1'b1 || lg_addr[n0+i] !== ea[i] ||
          lg_data[n0+i] !== ed[i]) begin
        $display("FAIL flush_xfer%0d got %b %h %h want 1 %h %h",
                 i, lg_we[n0+i], lg_addr[n0+i], lg_data[n0+i],
                 ea[i], ed[i]);
        errors++;
      end
    end
    n0 = lg_addr.size();
    dmemREN = 1'b1;
    dmemaddr = 32'h008;
    #1;
    checks++;
    if (dhit !== 1'b0) begin
      $display("FAIL halted_ignore got dhit=%b want 0", dhit);
      errors++;
    end
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (flushed !== 1'b1 || lg_addr.size() != n0) begin
      $display("FAIL flushed_sticky got %b n=%0d want 1 0",
               flushed, lg_addr.size() - n0);
      errors++;
    end
    dmemREN = 1'b0;
  endtask

  task automatic test_reset_abort;
    int n0, cyc;
    logic [31:0] ld;
    logic        found;
    @(negedge CLK);
    halt = 1'b0;
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    do_req(1'b0, 1'b1, 32'h200, 32'hBEEF0200, cyc, ld);
    do_req(1'b0, 1'b1, 32'h240, 32'hBEEF0240, cyc, ld);
    wait_cycles = 3;
    @(negedge CLK);
    dmemREN = 1'b1;
    dmemaddr = 32'h280;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK);
      #1;
      found = dWEN && (daddr == 32'h204);
    end
    checks++;
    if (found !== 1'b1) begin
      $display("FAIL reach_wb1 got %b want 1", found);
      errors++;
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (dWEN !== 1'b0 || dREN !== 1'b0 || dhit !== 1'b0) begin
      $display("FAIL abort_bus got %b %b %b want 0 0 0",
               dWEN, dREN, dhit);
      errors++;
    end
    @(negedge CLK);
    dmemREN = 1'b0;
    wait_cycles = 0;
    nRST = 1'b1;
    n0 = lg_addr.size();
    do_req(1'b1, 1'b0, 32'h200, 32'h0, cyc, ld);
    checks++;
    if (cyc != 3 || ld !== 32'hBEEF0200) begin
      $display("FAIL post_reset_miss got cyc=%0d %h want 3 beef0200",
               cyc, ld);
      errors++;
    end
    checks++;
    if (lg_addr.size() != n0 + 2 || lg_we[n0] !== 1'b0 ||
        lg_addr[n0] !== 32'h200) begin
      $display("FAIL post_reset_bus got n=%0d %b %h want 2 0 200",
               lg_addr.size() - n0, lg_we[n0], lg_addr[n0]);
      errors++;
    end
    do_req(1'b1, 1'b0, 32'h240, 32'h0, cyc, ld);
    checks++;
    if (cyc != 3 || ld !== dflt(32'h240)) begin
      $display("FAIL post_reset_way1 got cyc=%0d %h want 3 %h",
               cyc, ld, dflt(32'h240));
      errors++;
    end
  endtask

  initial begin
    bmem[32'h40] = 32'hAAAA0000;
    bmem[32'h44] = 32'hAAAA0004;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_evict();
    test_wait_states();
    test_flush();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
